// File: rtl/ubits_store_if.sv
// Used-bit store port bundle: index and update request from the cache side,
// registered old used bits and clear status back to the UBITS PAL.
interface ubits_store_if #(
  parameter int INDEX_W = 10
);
  logic [INDEX_W-1:0] INDEX;
  logic               LOOKUP;
  logic               UPDATE;
  logic               NUBI_n;
  logic               NUBD_n;
  logic               FLUSH;
  logic               OUBI;
  logic               OUBD;
  logic               BUSY;
  logic               FLUSH_DONE;

  modport master (
    output INDEX, LOOKUP, UPDATE, NUBI_n, NUBD_n, FLUSH,
    input  OUBI, OUBD, BUSY, FLUSH_DONE
  );

  modport slave (
    input  INDEX, LOOKUP, UPDATE, NUBI_n, NUBD_n, FLUSH,
    output OUBI, OUBD, BUSY, FLUSH_DONE
  );
endinterface

// File: rtl/ubits_store.sv
// Per-line I/D used-bit store with a one-cycle registered read, write-first bypass
// and a full-array clear sweep (one entry per cycle) on reset or flush.
module ubits_store #(
  parameter int INDEX_W      = 10,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic          CLK,
  input  logic          RESET,
  ubits_store_if.slave  bus
);
  localparam int                 DEPTH   = 1 << INDEX_W;
  localparam logic [INDEX_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;
  logic [INDEX_W-1:0] lidx_q, lidx_d;
  logic               lvalid_q, lvalid_d;
  logic [1:0]         oub_q, oub_d;
  logic               done_q, done_d;

  logic [1:0]         mem [DEPTH];
  logic               we;
  logic [INDEX_W-1:0] waddr;
  logic [1:0]         wdata;
  logic [1:0]         rdata;

  // A same-cycle write to the read address is forwarded so the read sees new data.
  assign rdata = (we && (waddr == bus.INDEX)) ? wdata : mem[bus.INDEX];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lidx_d   = lidx_q;
    lvalid_d = lvalid_q;
    oub_d    = oub_q;
    done_d   = 1'b0;
    we       = 1'b0;
    waddr    = lidx_q;
    wdata    = {~bus.NUBI_n, ~bus.NUBD_n};
    case (state_q)
      IDLE: begin
        if (bus.FLUSH) begin
          state_d  = CLEAR;
          cnt_d    = '0;
          lvalid_d = 1'b0;
          oub_d    = 2'b00;
        end else begin
          if (bus.UPDATE && lvalid_q) we = 1'b1;
          if (bus.LOOKUP) begin
            lidx_d   = bus.INDEX;
            lvalid_d = 1'b1;
            oub_d    = rdata;
          end
        end
      end
      CLEAR: begin
        we       = 1'b1;
        waddr    = cnt_q;
        wdata    = 2'b00;
        oub_d    = 2'b00;
        lvalid_d = 1'b0;
        if (bus.FLUSH) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= CLR_ON_RESET ? CLEAR : IDLE;
      cnt_q    <= '0;
      lidx_q   <= '0;
      lvalid_q <= 1'b0;
      oub_q    <= 2'b00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lidx_q   <= lidx_d;
      lvalid_q <= lvalid_d;
      oub_q    <= oub_d;
      done_q   <= done_d;
    end
  end

  // Storage carries no reset; the sweep is what clears it.
  always_ff @(posedge CLK) begin
    if (!RESET && we) mem[waddr] <= wdata;
  end

  assign bus.OUBI       = oub_q[1];
  assign bus.OUBD       = oub_q[0];
  assign bus.BUSY       = (state_q == CLEAR);
  assign bus.FLUSH_DONE = done_q;
endmodule
